// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state encodings,
// opcodes, ALU/PC select codes and the bundle of datapath control bits.
package mc_pkg;

    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_J    = 4'd2,
        S_BR   = 4'd3,
        S_RT1  = 4'd4,
        S_RT2  = 4'd5,
        S_MA   = 4'd6,
        S_MW   = 4'd7,
        S_MR   = 4'd8,
        S_WB   = 4'd9,
        S_JAL  = 4'd10,
        S_AI   = 4'd11,
        S_WI   = 4'd12,
        S_SI   = 4'd13,
        S_JR   = 4'd14,
        S_TRAP = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_JR    = 6'b000110;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_SUB  = 2'b01,
        ALU_FUNC = 2'b10,
        ALU_SLT  = 2'b11
    } alu_op_t;

    typedef enum logic [2:0] {
        PC_ALU    = 3'b000,
        PC_JUMP   = 3'b001,
        PC_ALUOUT = 3'b010,
        PC_REGA   = 3'b011,
        PC_EXC    = 3'b100
    } pc_src_t;

    // ALU operation encodings driven onto the datapath ALU
    localparam logic [2:0] OPR_AND = 3'b000;
    localparam logic [2:0] OPR_OR  = 3'b001;
    localparam logic [2:0] OPR_ADD = 3'b010;
    localparam logic [2:0] OPR_SUB = 3'b110;
    localparam logic [2:0] OPR_SLT = 3'b111;

    typedef struct packed {
        logic        iord;
        logic        mem_read;
        logic        mem_write;
        logic        ir_write;
        logic        reg_dst;
        logic        reg_dst2;
        logic        mem_to_reg;
        logic        reg_write;
        logic        data_write;
        logic        alu_src_a;
        logic [1:0]  alu_src_b;
        pc_src_t     pc_src;
        alu_op_t     alu_op;
        logic        pc_write;
        logic        pc_write_cond;
        logic        branch_ne;
        logic        exc;
    } ctrl_t;

endpackage

// File: rtl/mc_fsm_ctrl_alu_controller.sv
// ALU controller: maps the FSM's coarse alu_op plus the R-type funct field
// onto the 3-bit ALU operation.
module alu_controller
    import mc_pkg::*;
(
    input  alu_op_t     alu_op,
    input  logic [5:0]  func,
    output logic [2:0]  operation
);

    always_comb begin
        operation = OPR_ADD;
        case (alu_op)
            ALU_ADD: operation = OPR_ADD;
            ALU_SUB: operation = OPR_SUB;
            ALU_SLT: operation = OPR_SLT;
            ALU_FUNC: begin
                case (func)
                    6'b100000: operation = OPR_ADD;
                    6'b100010: operation = OPR_SUB;
                    6'b100100: operation = OPR_AND;
                    6'b100101: operation = OPR_OR;
                    6'b101010: operation = OPR_SLT;
                    default:   operation = OPR_ADD;
                endcase
            end
            default: operation = OPR_ADD;
        endcase
    end

endmodule

// File: rtl/mc_fsm_ctrl.sv
// Multi-cycle MIPS control FSM with memory wait states, optional bne,
// illegal-opcode trap and a retired-instruction counter.
module mc_fsm_ctrl
    import mc_pkg::*;
#(
    parameter bit MEM_HS  = 1'b1,
    parameter bit BNE_EN  = 1'b1,
    parameter bit TRAP_EN = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             IorD,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             reg_dst2,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             data_write,
    output logic             alu_srcA,
    output logic [1:0]       alu_srcB,
    output logic [2:0]       pc_src,
    output logic [2:0]       operation,
    output logic             pc_load,
    output logic             exc,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [3:0]       state_o
);

    state_t state, state_nxt;
    state_t illegal_nxt;
    ctrl_t  ctrl_raw, ctrl;
    logic   ready;

    assign ready       = MEM_HS ? mem_ready : 1'b1;
    assign illegal_nxt = TRAP_EN ? S_TRAP : S_IF;

    // An instruction retires whenever control returns to IF from elsewhere.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IF;
            retire_cnt <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state <= state_nxt;
            if (state != S_IF && state_nxt == S_IF)
                retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        // NOTE: defaulting every always_comb output first prevents latches on
        // paths that a case arm leaves unassigned.
        state_nxt = S_IF;
        case (state)
            S_IF: state_nxt = ready ? S_ID : S_IF;
            S_ID: begin
                case (opcode)
                    OP_RTYPE:     state_nxt = S_RT1;
                    OP_LW, OP_SW: state_nxt = S_MA;
                    OP_BEQ:       state_nxt = S_BR;
                    OP_BNE:       state_nxt = BNE_EN ? S_BR : illegal_nxt;
                    OP_ADDI:      state_nxt = S_AI;
                    OP_SLTI:      state_nxt = S_SI;
                    OP_J:         state_nxt = S_J;
                    OP_JAL:       state_nxt = S_JAL;
                    OP_JR:        state_nxt = S_JR;
                    default:      state_nxt = illegal_nxt;
                endcase
            end
            S_RT1:      state_nxt = S_RT2;
            S_MA:       state_nxt = (opcode == OP_SW) ? S_MW : S_MR;
            S_MW:       state_nxt = ready ? S_IF : S_MW;
            S_MR:       state_nxt = ready ? S_WB : S_MR;
            S_AI, S_SI: state_nxt = S_WI;
            default:    state_nxt = S_IF;
        endcase
    end

    always_comb begin
        ctrl_raw = '0;
        case (state)
            S_IF: begin
                ctrl_raw.mem_read  = 1'b1;
                ctrl_raw.alu_src_b = 2'b01;
                ctrl_raw.ir_write  = ready;
                ctrl_raw.pc_write  = ready;
            end
            S_ID: ctrl_raw.alu_src_b = 2'b11;
            S_J: begin
                ctrl_raw.pc_write = 1'b1;
                ctrl_raw.pc_src   = PC_JUMP;
            end
            S_BR: begin
                ctrl_raw.alu_src_a     = 1'b1;
                ctrl_raw.alu_op        = ALU_SUB;
                ctrl_raw.pc_write_cond = 1'b1;
                ctrl_raw.pc_src        = PC_ALUOUT;
                ctrl_raw.branch_ne     = (opcode == OP_BNE);
            end
            S_RT1: begin
                ctrl_raw.alu_src_a = 1'b1;
                ctrl_raw.alu_op    = ALU_FUNC;
            end
            S_RT2: begin
                ctrl_raw.reg_dst   = 1'b1;
                ctrl_raw.reg_write = 1'b1;
            end
            S_MA, S_AI: begin
                ctrl_raw.alu_src_a = 1'b1;
                ctrl_raw.alu_src_b = 2'b10;
            end
            S_SI: begin
                ctrl_raw.alu_src_a = 1'b1;
                ctrl_raw.alu_src_b = 2'b10;
                ctrl_raw.alu_op    = ALU_SLT;
            end
            S_MW: begin
                ctrl_raw.iord      = 1'b1;
                ctrl_raw.mem_write = 1'b1;
            end
            S_MR: begin
                ctrl_raw.iord     = 1'b1;
                ctrl_raw.mem_read = 1'b1;
            end
            S_WB: begin
                ctrl_raw.mem_to_reg = 1'b1;
                ctrl_raw.reg_write  = 1'b1;
            end
            S_WI: ctrl_raw.reg_write = 1'b1;
            S_JAL: begin
                ctrl_raw.reg_write  = 1'b1;
                ctrl_raw.reg_dst2   = 1'b1;
                ctrl_raw.data_write = 1'b1;
                ctrl_raw.pc_write   = 1'b1;
                ctrl_raw.pc_src     = PC_JUMP;
            end
            S_JR: begin
                ctrl_raw.pc_write = 1'b1;
                ctrl_raw.pc_src   = PC_REGA;
            end
            S_TRAP: begin
                ctrl_raw.pc_write = 1'b1;
                ctrl_raw.pc_src   = PC_EXC;
                ctrl_raw.exc      = 1'b1;
            end
            default: ctrl_raw = '0;
        endcase
    end

    // Reset kills the IF-state fetch strobes immediately, not at the next edge.
    assign ctrl = rst ? ctrl_raw : '0;

    alu_controller u_alu_ctrl (
        .alu_op    (ctrl.alu_op),
        .func      (func),
        .operation (operation)
    );

    assign IorD       = ctrl.iord;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign ir_write   = ctrl.ir_write;
    assign reg_dst    = ctrl.reg_dst;
    assign reg_dst2   = ctrl.reg_dst2;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign reg_write  = ctrl.reg_write;
    assign data_write = ctrl.data_write;
    assign alu_srcA   = ctrl.alu_src_a;
    assign alu_srcB   = ctrl.alu_src_b;
    assign pc_src     = ctrl.pc_src;
    assign exc        = ctrl.exc;
    assign pc_load    = ctrl.pc_write | (ctrl.pc_write_cond & (zero ^ ctrl.branch_ne));
    assign state_o    = state;

endmodule

// File: tb/tb_mc_fsm_ctrl.sv
// Directed bench for mc_fsm_ctrl: default configuration plus a second instance
// with no handshake, no bne, no trap and a 2-bit retire counter.
module tb_mc_fsm_ctrl;

    logic       clk = 1'b0;
    logic       rst, rst2;
    logic [5:0] opcode, func, opcode2;
    logic       zero, mem_ready;

    logic       IorD, mem_read, mem_write, ir_write, reg_dst, reg_dst2;
    logic       mem_to_reg, reg_write, data_write, alu_srcA, pc_load, exc;
    logic [1:0] alu_srcB;
    logic [2:0] pc_src, operation;
    logic [15:0] retire_cnt;
    logic [3:0] state_o;

    logic       b_IorD, b_mem_read, b_mem_write, b_ir_write, b_reg_dst, b_reg_dst2;
    logic       b_mem_to_reg, b_reg_write, b_data_write, b_alu_srcA, b_pc_load, b_exc;
    logic [1:0] b_alu_srcB;
    logic [2:0] b_pc_src, b_operation;
    logic [1:0] b_retire_cnt;
    logic [3:0] b_state_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mc_fsm_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
        .mem_ready(mem_ready), .IorD(IorD), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .reg_dst2(reg_dst2), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .data_write(data_write), .alu_srcA(alu_srcA), .alu_srcB(alu_srcB),
        .pc_src(pc_src), .operation(operation), .pc_load(pc_load), .exc(exc),
        .retire_cnt(retire_cnt), .state_o(state_o)
    );

    mc_fsm_ctrl #(.MEM_HS(1'b0), .BNE_EN(1'b0), .TRAP_EN(1'b0), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst2), .opcode(opcode2), .func(6'b000000), .zero(1'b0),
        .mem_ready(1'b0), .IorD(b_IorD), .mem_read(b_mem_read),
        .mem_write(b_mem_write), .ir_write(b_ir_write), .reg_dst(b_reg_dst),
        .reg_dst2(b_reg_dst2), .mem_to_reg(b_mem_to_reg), .reg_write(b_reg_write),
        .data_write(b_data_write), .alu_srcA(b_alu_srcA), .alu_srcB(b_alu_srcB),
        .pc_src(b_pc_src), .operation(b_operation), .pc_load(b_pc_load), .exc(b_exc),
        .retire_cnt(b_retire_cnt), .state_o(b_state_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_branch(input logic [5:0] op, input logic z, input logic exp_load,
                              input string tag);
        opcode = op;
        zero   = z;
        tick();
        check({tag, "_id"}, state_o, 4'd1);
        tick();
        check({tag, "_br"}, state_o, 4'd3);
        check({tag, "_pc_src"}, pc_src, 3'b010);
        check({tag, "_op"}, operation, 3'b110);
        check({tag, "_pc_load"}, pc_load, exp_load);
        tick();
        check({tag, "_if"}, state_o, 4'd0);
    endtask

    initial begin
        logic [1:0] j_cnt_exp [5];
        j_cnt_exp[0] = 2'd1; j_cnt_exp[1] = 2'd2; j_cnt_exp[2] = 2'd3;
        j_cnt_exp[3] = 2'd0; j_cnt_exp[4] = 2'd1;

        rst = 1'b0; rst2 = 1'b0;
        opcode = OP_LW_C(); func = 6'b000000; zero = 1'b1; mem_ready = 1'b1;
        opcode2 = 6'b000010;

        // Reset held 3 cycles with ready high: IF strobes must stay masked
        repeat (3) tick();
        check("rst_state", state_o, 4'd0);
        check("rst_mem_read", mem_read, 1'b0);
        check("rst_ir_write", ir_write, 1'b0);
        check("rst_pc_load", pc_load, 1'b0);
        check("rst_alu_srcB", alu_srcB, 2'b00);
        check("rst_operation", operation, 3'b010);
        check("rst_retire", retire_cnt, 16'd0);
        check("rst_b_mem_read", b_mem_read, 1'b0);

        rst = 1'b1;
        #1;
        check("if_mem_read", mem_read, 1'b1);
        check("if_alu_srcB", alu_srcB, 2'b01);
        check("if_ir_write", ir_write, 1'b1);
        check("if_pc_load", pc_load, 1'b1);
        mem_ready = 1'b0;
        #1;
        check("if_wait_ir_write", ir_write, 1'b0);
        check("if_wait_pc_load", pc_load, 1'b0);
        tick();
        check("if_hold", state_o, 4'd0);

        // sw stalled in MW, then aborted by reset
        opcode = 6'b101011; mem_ready = 1'b1;
        tick();
        check("sw_id", state_o, 4'd1);
        check("sw_id_srcB", alu_srcB, 2'b11);
        tick();
        check("sw_ma", state_o, 4'd6);
        check("sw_ma_srcB", alu_srcB, 2'b10);
        mem_ready = 1'b0;
        tick();
        check("sw_mw", state_o, 4'd7);
        check("sw_mw_write", mem_write, 1'b1);
        check("sw_mw_iord", IorD, 1'b1);
        tick();
        check("sw_mw_hold", state_o, 4'd7);
        rst = 1'b0;
        #1;
        check("sw_abort_state", state_o, 4'd0);
        check("sw_abort_write", mem_write, 1'b0);
        check("sw_abort_retire", retire_cnt, 16'd0);
        tick();
        rst = 1'b1; mem_ready = 1'b1;
        #1;

        // sw without wait: IF, ID, MA, MW
        tick(); tick(); tick();
        check("sw2_mw", state_o, 4'd7);
        check("sw2_write", mem_write, 1'b1);
        tick();
        check("sw2_if", state_o, 4'd0);
        check("sw2_retire", retire_cnt, 16'd1);

        // lw with two MR wait cycles
        opcode = 6'b100011;
        tick();
        check("lw_id", state_o, 4'd1);
        tick();
        check("lw_ma", state_o, 4'd6);
        mem_ready = 1'b0;
        tick();
        check("lw_mr1", state_o, 4'd8);
        check("lw_mr1_read", mem_read, 1'b1);
        check("lw_mr1_regw", reg_write, 1'b0);
        tick();
        check("lw_mr2", state_o, 4'd8);
        tick();
        check("lw_mr3", state_o, 4'd8);
        check("lw_mr3_regw", reg_write, 1'b0);
        mem_ready = 1'b1;
        tick();
        check("lw_wb", state_o, 4'd9);
        check("lw_wb_regw", reg_write, 1'b1);
        check("lw_wb_m2r", mem_to_reg, 1'b1);
        tick();
        check("lw_if", state_o, 4'd0);
        check("lw_if_regw", reg_write, 1'b0);
        check("lw_retire", retire_cnt, 16'd2);

        run_branch(6'b000100, 1'b1, 1'b1, "beq_z1");
        run_branch(6'b000100, 1'b0, 1'b0, "beq_z0");
        run_branch(6'b000101, 1'b1, 1'b0, "bne_z1");
        run_branch(6'b000101, 1'b0, 1'b1, "bne_z0");
        check("br_retire", retire_cnt, 16'd6);

        // R-type sub
        opcode = 6'b000000; func = 6'b100010;
        tick(); tick();
        check("rt1", state_o, 4'd4);
        check("rt1_op", operation, 3'b110);
        check("rt1_srcA", alu_srcA, 1'b1);
        tick();
        check("rt2", state_o, 4'd5);
        check("rt2_regdst", reg_dst, 1'b1);
        check("rt2_regw", reg_write, 1'b1);
        tick();
        check("rt_retire", retire_cnt, 16'd7);

        // addi then slti
        opcode = 6'b001001;
        tick(); tick();
        check("ai", state_o, 4'd11);
        check("ai_op", operation, 3'b010);
        tick();
        check("wi", state_o, 4'd12);
        check("wi_regw", reg_write, 1'b1);
        tick();
        opcode = 6'b001010;
        tick(); tick();
        check("si", state_o, 4'd13);
        check("si_op", operation, 3'b111);
        tick(); tick();
        check("si_retire", retire_cnt, 16'd9);

        // jal and jr
        opcode = 6'b000011;
        tick(); tick();
        check("jal", state_o, 4'd10);
        check("jal_dst2", reg_dst2, 1'b1);
        check("jal_dw", data_write, 1'b1);
        check("jal_pc_src", pc_src, 3'b001);
        check("jal_pc_load", pc_load, 1'b1);
        tick();
        opcode = 6'b000110;
        tick(); tick();
        check("jr", state_o, 4'd14);
        check("jr_pc_src", pc_src, 3'b011);
        tick();
        check("jr_retire", retire_cnt, 16'd11);

        // Illegal opcode trap
        opcode = 6'b111111;
        tick();
        check("trap_id_exc", exc, 1'b0);
        tick();
        check("trap", state_o, 4'd15);
        check("trap_exc", exc, 1'b1);
        check("trap_pc_src", pc_src, 3'b100);
        check("trap_pc_load", pc_load, 1'b1);
        tick();
        check("trap_if", state_o, 4'd0);
        check("trap_exc_off", exc, 1'b0);
        check("trap_retire", retire_cnt, 16'd12);

        // Second instance: 5 jumps with a 2-bit counter, ready ignored
        rst2 = 1'b1;
        #1;
        check("b_if_ir_write", b_ir_write, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            tick();
            check("b_j_state", b_state_o, 4'd2);
            tick();
            check("b_j_retire", b_retire_cnt, j_cnt_exp[k]);
        end

        // Illegal opcode without trap returns as a no-op
        opcode2 = 6'b111111;
        tick();
        check("b_ill_id", b_state_o, 4'd1);
        tick();
        check("b_ill_if", b_state_o, 4'd0);
        check("b_ill_exc", b_exc, 1'b0);
        check("b_ill_retire", b_retire_cnt, 2'd2);

        // bne disabled: behaves as illegal no-op
        opcode2 = 6'b000101;
        tick(); tick();
        check("b_bne_if", b_state_o, 4'd0);
        check("b_bne_retire", b_retire_cnt, 2'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    function automatic logic [5:0] OP_LW_C();
        return 6'b100011;
    endfunction

endmodule
